// File: rtl/vga_pkg.sv
// Shared timing constants, register init values and control-byte layout for the text scanout.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

    // 640x480@60 timing, 25 MHz pixel clock
    localparam int H_VISIBLE    = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int V_VISIBLE    = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;

    // 80x30 text screen of 8x16 cells
    localparam int COLS         = 80;
    localparam int ROWS         = 30;
    localparam int BLINK_FRAMES = 16;

    // Values the shadow registers hold out of reset
    localparam logic [7:0] CTL_INIT = 8'hF5;
    localparam logic [7:0] CRX_INIT = 8'h28;
    localparam logic [7:0] CRY_INIT = 8'h14;

    // Control byte field positions
    localparam int CTL_EN_BIT     = 0;
    localparam int CTL_BLINK_BIT  = 1;
    localparam int CTL_BLOCK_BIT  = 2;
    localparam int CTL_COLOUR_LSB = 4;

    typedef struct packed {
        logic [3:0] colour;  // [7:4]
        logic       rsvd;    // [3]
        logic       block;   // [2] block(1) / underline(0)
        logic       blink;   // [1]
        logic       en;      // [0]
    } ctl_t;

    // row*80 + col without a multiplier
    function automatic logic [11:0] char_addr(input logic [4:0] row, input logic [6:0] col);
        return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters with sync, visible and frame-load decode.
// Latency: decodes are combinational from the counter registers (stage 0).
// Backpressure: none; free-running every cycle.
// Ports: i_clock/i_reset (sync, active-high); o_hcount/o_vcount counters;
//        o_visible, o_hsync_l, o_vsync_l, o_frame_load (HCount==0 && VCount==V_VISIBLE).
module vga_timing_gen #(
    parameter int P_H_VISIBLE = 640,
    parameter int P_H_FP      = 16,
    parameter int P_H_SYNC    = 96,
    parameter int P_H_BP      = 48,
    parameter int P_V_VISIBLE = 480,
    parameter int P_V_FP      = 10,
    parameter int P_V_SYNC    = 2,
    parameter int P_V_BP      = 33
) (
    input  logic       i_clock,
    input  logic       i_reset,
    output logic [9:0] o_hcount,
    output logic [9:0] o_vcount,
    output logic       o_visible,
    output logic       o_hsync_l,
    output logic       o_vsync_l,
    output logic       o_frame_load
);
    localparam int H_TOTAL = P_H_VISIBLE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int V_TOTAL = P_V_VISIBLE + P_V_FP + P_V_SYNC + P_V_BP;

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_hcount == 10'(H_TOTAL - 1));
    assign w_v_last = (r_vcount == 10'(V_TOTAL - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_h_last) begin
            r_hcount <= '0;
            r_vcount <= w_v_last ? 10'd0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 10'd1;
        end
    end

    assign o_hcount     = r_hcount;
    assign o_vcount     = r_vcount;
    assign o_visible    = (r_hcount < 10'(P_H_VISIBLE)) && (r_vcount < 10'(P_V_VISIBLE));
    assign o_hsync_l    = !((r_hcount >= 10'(P_H_VISIBLE + P_H_FP)) &&
                            (r_hcount <  10'(P_H_VISIBLE + P_H_FP + P_H_SYNC)));
    assign o_vsync_l    = !((r_vcount >= 10'(P_V_VISIBLE + P_V_FP)) &&
                            (r_vcount <  10'(P_V_VISIBLE + P_V_FP + P_V_SYNC)));
    // First blanked line start: cursor state can change here without tearing
    assign o_frame_load = (r_hcount == 10'd0) && (r_vcount == 10'(P_V_VISIBLE));

endmodule

// File: rtl/vga_text_scanout.sv
// Text-mode scanout: char-RAM address/font row, syncs, blank and a blinkable cursor overlay.
// Latency: CharAddr/FontRow 1 cycle after the counters; all other outputs 2 cycles (aligned with RAM data).
// Backpressure: none; one pixel per clock, no stalls.
// Ports: i_clock/i_reset (sync, active-high); i_octl/i_ocrx/i_ocry cursor registers;
//        o_char_addr, o_font_row, o_pixel_col, o_hsync_l, o_vsync_l, o_vga_blanking_l,
//        o_cursor_on, o_cursor_colour, o_frame_start.
module vga_text_scanout
    import vga_pkg::*;
#(
    parameter int P_H_VISIBLE    = H_VISIBLE,
    parameter int P_H_FP         = H_FP,
    parameter int P_H_SYNC       = H_SYNC,
    parameter int P_H_BP         = H_BP,
    parameter int P_V_VISIBLE    = V_VISIBLE,
    parameter int P_V_FP         = V_FP,
    parameter int P_V_SYNC       = V_SYNC,
    parameter int P_V_BP         = V_BP,
    parameter int P_BLINK_FRAMES = BLINK_FRAMES
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_octl,
    input  logic [7:0]  i_ocrx,
    input  logic [7:0]  i_ocry,
    output logic [11:0] o_char_addr,
    output logic [3:0]  o_font_row,
    output logic [2:0]  o_pixel_col,
    output logic        o_hsync_l,
    output logic        o_vsync_l,
    output logic        o_vga_blanking_l,
    output logic        o_cursor_on,
    output logic [3:0]  o_cursor_colour,
    output logic        o_frame_start
);
    localparam int FC_W = (P_BLINK_FRAMES > 1) ? $clog2(P_BLINK_FRAMES) : 1;

    // Stage 0
    logic [9:0] w_hcount;
    logic [9:0] w_vcount;
    logic       w_visible;
    logic       w_hsync_l;
    logic       w_vsync_l;
    logic       w_frame_load;
    logic       w_cursor_hit;
    logic       w_unused;

    // Frame-stable copies of the CPU registers and blink state
    ctl_t            r_sh_ctl;
    logic [7:0]      r_sh_crx;
    logic [7:0]      r_sh_cry;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_blink_phase;

    // Stage 1
    logic [11:0] r_char_addr;
    logic [3:0]  r_font_row;
    logic [2:0]  r_s1_pix;
    logic        r_s1_hsync_l;
    logic        r_s1_vsync_l;
    logic        r_s1_vis;
    logic        r_s1_cursor;
    logic [3:0]  r_s1_colour;
    logic        r_s1_fstart;

    // Stage 2
    logic [2:0]  r_pixel_col;
    logic        r_hsync_l;
    logic        r_vsync_l;
    logic        r_blanking_l;
    logic        r_cursor_on;
    logic [3:0]  r_cursor_colour;
    logic        r_frame_start;

    vga_timing_gen #(
        .P_H_VISIBLE (P_H_VISIBLE),
        .P_H_FP      (P_H_FP),
        .P_H_SYNC    (P_H_SYNC),
        .P_H_BP      (P_H_BP),
        .P_V_VISIBLE (P_V_VISIBLE),
        .P_V_FP      (P_V_FP),
        .P_V_SYNC    (P_V_SYNC),
        .P_V_BP      (P_V_BP)
    ) u_timing (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .o_hcount     (w_hcount),
        .o_vcount     (w_vcount),
        .o_visible    (w_visible),
        .o_hsync_l    (w_hsync_l),
        .o_vsync_l    (w_vsync_l),
        .o_frame_load (w_frame_load)
    );

    // Reserved control bit and the counter MSB (always 0 while visible) carry no meaning here
    assign w_unused = ^{r_sh_ctl.rsvd, w_vcount[9]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sh_ctl      <= ctl_t'(CTL_INIT);
            r_sh_crx      <= CRX_INIT;
            r_sh_cry      <= CRY_INIT;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_load) begin
            r_sh_ctl <= ctl_t'(i_octl);
            r_sh_crx <= i_ocrx;
            r_sh_cry <= i_ocry;
            if (r_frame_cnt == FC_W'(P_BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Out-of-range positions never match because the range test gates the whole term.
    // Underline uses the last two scanlines of the cell (14, 15).
    assign w_cursor_hit = w_visible && r_sh_ctl.en &&
                          (r_sh_crx < 8'(COLS)) && (r_sh_cry < 8'(ROWS)) &&
                          ({1'b0, w_hcount[9:3]} == r_sh_crx) &&
                          ({3'b0, w_vcount[8:4]} == r_sh_cry) &&
                          (r_sh_ctl.block || (w_vcount[3:1] == 3'b111)) &&
                          (!r_sh_ctl.blink || r_blink_phase);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_char_addr     <= '0;
            r_font_row      <= '0;
            r_s1_pix        <= '0;
            r_s1_hsync_l    <= 1'b1;
            r_s1_vsync_l    <= 1'b1;
            r_s1_vis        <= 1'b0;
            r_s1_cursor     <= 1'b0;
            r_s1_colour     <= '0;
            r_s1_fstart     <= 1'b0;
            r_pixel_col     <= '0;
            r_hsync_l       <= 1'b1;
            r_vsync_l       <= 1'b1;
            r_blanking_l    <= 1'b0;
            r_cursor_on     <= 1'b0;
            r_cursor_colour <= '0;
            r_frame_start   <= 1'b0;
        end else begin
            r_char_addr     <= w_visible ? char_addr(w_vcount[8:4], w_hcount[9:3]) : 12'd0;
            r_font_row      <= w_vcount[3:0];
            r_s1_pix        <= w_hcount[2:0];
            r_s1_hsync_l    <= w_hsync_l;
            r_s1_vsync_l    <= w_vsync_l;
            r_s1_vis        <= w_visible;
            r_s1_cursor     <= w_cursor_hit;
            r_s1_colour     <= r_sh_ctl.colour;
            r_s1_fstart     <= w_frame_load;
            r_pixel_col     <= r_s1_pix;
            r_hsync_l       <= r_s1_hsync_l;
            r_vsync_l       <= r_s1_vsync_l;
            r_blanking_l    <= r_s1_vis;
            r_cursor_on     <= r_s1_cursor;
            r_cursor_colour <= r_s1_colour;
            r_frame_start   <= r_s1_fstart;
        end
    end

    assign o_char_addr      = r_char_addr;
    assign o_font_row       = r_font_row;
    assign o_pixel_col      = r_pixel_col;
    assign o_hsync_l        = r_hsync_l;
    assign o_vsync_l        = r_vsync_l;
    assign o_vga_blanking_l = r_blanking_l;
    assign o_cursor_on      = r_cursor_on;
    assign o_cursor_colour  = r_cursor_colour;
    assign o_frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_text_scanout.sv
// Bench for vga_text_scanout: one instance at full 640x480 timing, one at a shrunken timing
// (80x54 total, 64x48 visible, 2-frame blink) so whole frames fit a short run.
// A per-cycle reference model checks both instances; directed checks pin hand-computed values.
module tb_vga_text_scanout;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  frow;
        logic [2:0]  pcol;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        cur;
        logic [3:0]  col;
        logic        fs;
    } obs_t;

    // Index 0: full timing, index 1: small timing
    localparam int HVIS[2] = '{640, 64};
    localparam int HFP[2]  = '{16, 4};
    localparam int HSY[2]  = '{96, 8};
    localparam int HT[2]   = '{800, 80};
    localparam int VVIS[2] = '{480, 48};
    localparam int VFP[2]  = '{10, 2};
    localparam int VSY[2]  = '{2, 2};
    localparam int VT[2]   = '{525, 54};
    localparam int BLK[2]  = '{16, 2};

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst;
    logic [7:0] ctl, crx, cry;

    logic [11:0] d_addr, s_addr;
    logic [3:0]  d_frow, s_frow, d_col, s_col;
    logic [2:0]  d_pcol, s_pcol;
    logic        d_hs, d_vs, d_bl, d_cur, d_fs;
    logic        s_hs, s_vs, s_bl, s_cur, s_fs;
    obs_t        d_obs, s_obs;

    assign d_obs = {d_addr, d_frow, d_pcol, d_hs, d_vs, d_bl, d_cur, d_col, d_fs};
    assign s_obs = {s_addr, s_frow, s_pcol, s_hs, s_vs, s_bl, s_cur, s_col, s_fs};

    vga_text_scanout u_dut (
        .i_clock(clk), .i_reset(rst), .i_octl(ctl), .i_ocrx(crx), .i_ocry(cry),
        .o_char_addr(d_addr), .o_font_row(d_frow), .o_pixel_col(d_pcol),
        .o_hsync_l(d_hs), .o_vsync_l(d_vs), .o_vga_blanking_l(d_bl),
        .o_cursor_on(d_cur), .o_cursor_colour(d_col), .o_frame_start(d_fs)
    );

    vga_text_scanout #(
        .P_H_VISIBLE(64), .P_H_FP(4), .P_H_SYNC(8), .P_H_BP(4),
        .P_V_VISIBLE(48), .P_V_FP(2), .P_V_SYNC(2), .P_V_BP(2),
        .P_BLINK_FRAMES(2)
    ) u_small (
        .i_clock(clk), .i_reset(rst), .i_octl(ctl), .i_ocrx(crx), .i_ocry(cry),
        .o_char_addr(s_addr), .o_font_row(s_frow), .o_pixel_col(s_pcol),
        .o_hsync_l(s_hs), .o_vsync_l(s_vs), .o_vga_blanking_l(s_bl),
        .o_cursor_on(s_cur), .o_cursor_colour(s_col), .o_frame_start(s_fs)
    );

    int checks = 0;
    int errors = 0;
    int nprint = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // n = clock edges since reset was last sampled; the screen position being scanned
    // in the cycle after n edges is pixel index n (row-major over the whole frame).
    int         n;
    logic [7:0] m_ctl[2], m_crx[2], m_cry[2];
    int         m_fc[2];
    bit         m_ph[2];
    logic [3:0] m_hist[2][3];

    function automatic bit is_load(int i, int k);
        return (k >= 0) && (k % HT[i] == 0) && ((k / HT[i]) % VT[i] == VVIS[i]);
    endfunction

    function automatic obs_t expect_out(int i);
        obs_t e;
        int   k1, k2, h, v;
        bit   vis;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        k1   = n - 1;
        k2   = n - 2;
        if (k1 >= 0) begin
            h      = k1 % HT[i];
            v      = (k1 / HT[i]) % VT[i];
            e.frow = 4'(v % 16);
            if (h < HVIS[i] && v < VVIS[i]) e.addr = 12'((v / 16) * 80 + h / 8);
        end
        if (k2 >= 0) begin
            h      = k2 % HT[i];
            v      = (k2 / HT[i]) % VT[i];
            vis    = (h < HVIS[i]) && (v < VVIS[i]);
            e.pcol = 3'(h % 8);
            e.hs   = !(h >= HVIS[i] + HFP[i] && h < HVIS[i] + HFP[i] + HSY[i]);
            e.vs   = !(v >= VVIS[i] + VFP[i] && v < VVIS[i] + VFP[i] + VSY[i]);
            e.bl   = vis;
            e.fs   = is_load(i, k2);
            e.cur  = vis && m_ctl[i][0] && (m_crx[i] < 80) && (m_cry[i] < 30) &&
                     (h / 8 == int'(m_crx[i])) && (v / 16 == int'(m_cry[i])) &&
                     (m_ctl[i][2] || (v % 16 >= 14)) && (!m_ctl[i][1] || m_ph[i]);
        end
        e.col = (n < 2) ? 4'd0 : m_hist[i][1];
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n <= 0;
            for (int i = 0; i < 2; i++) begin
                m_ctl[i] <= 8'hF5;
                m_crx[i] <= 8'h28;
                m_cry[i] <= 8'h14;
                m_fc[i]  <= 0;
                m_ph[i]  <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (is_load(i, n)) begin
                    m_ctl[i] <= ctl;
                    m_crx[i] <= crx;
                    m_cry[i] <= cry;
                    if (m_fc[i] == BLK[i] - 1) begin
                        m_fc[i] <= 0;
                        m_ph[i] <= !m_ph[i];
                    end else begin
                        m_fc[i] <= m_fc[i] + 1;
                    end
                end
            end
            n <= n + 1;
        end
    end

    // Compare process: every cycle, both instances
    always @(negedge clk) begin
        obs_t e, a;
        for (int i = 0; i < 2; i++) begin
            e = expect_out(i);
            a = (i == 0) ? d_obs : s_obs;
            checks++;
            if (a !== e) begin
                errors++;
                if (nprint < 20)
                    $display("FAIL cycle_cmp inst=%0d n=%0d actual=%h expected=%h", i, n, a, e);
                nprint++;
            end
            m_hist[i][2] = m_hist[i][1];
            m_hist[i][1] = m_hist[i][0];
            m_hist[i][0] = m_ctl[i][7:4];
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_pulse();
        int t = 0;
        while (s_fs !== 1'b1 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (s_fs !== 1'b1) chk("frame_start_timeout", 0, 1);
    endtask

    // Called on a FrameStart cycle; runs to the next one and summarises the frame
    task automatic measure(output int cnt, output int fx, output int fy, output int hsf,
                           output int vsl, output int len, output int colr);
        bit prev_hs = 1'b1;
        cnt = 0; fx = -1; fy = -1; hsf = 0; vsl = 0; len = 0; colr = -1;
        do begin
            @(negedge clk);
            len++;
            if (s_cur === 1'b1) begin
                if (cnt == 0) begin
                    fx   = (n - 2) % 80;
                    fy   = ((n - 2) / 80) % 54;
                    colr = int'(s_col);
                end
                cnt++;
            end
            if (prev_hs && s_hs === 1'b0) hsf++;
            prev_hs = s_hs;
            if (s_vs === 1'b0) vsl++;
        end while (s_fs !== 1'b1 && len < 6000);
        if (len >= 6000) chk("measure_timeout", len, 4320);
    endtask

    initial begin
        int c, fx, fy, hsf, vsl, len, colr, t;
        rst = 1'b1;
        ctl = 8'hF5;
        crx = 8'd5;
        cry = 8'd2;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        fork
            // -------- full-timing instance --------
            begin
                chk("rst_char_addr", int'(d_addr), 0);
                chk("rst_font_row", int'(d_frow), 0);
                chk("rst_pixel_col", int'(d_pcol), 0);
                chk("rst_hsync_l", int'(d_hs), 1);
                chk("rst_vsync_l", int'(d_vs), 1);
                chk("rst_blank_l", int'(d_bl), 0);
                chk("rst_cursor_on", int'(d_cur), 0);
                chk("rst_colour", int'(d_col), 0);
                chk("rst_frame_start", int'(d_fs), 0);
                @(negedge clk);
                chk("blank_after_1", int'(d_bl), 0);
                @(negedge clk);
                chk("blank_after_2", int'(d_bl), 1);
                t = 2;
                while (d_hs !== 1'b0 && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                chk("first_hsync_fall", t, 658);
                t = 0;
                while (d_hs === 1'b0 && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                chk("hsync_low_width", t, 96);
                t = 96;
                while (d_hs !== 1'b0 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                chk("line_period", t, 800);
                t = 0;
                while (n != 25641 && t < 30000) begin
                    @(negedge clk);
                    t++;
                end
                chk("char_addr_r2c5", int'(d_addr), 165);
                chk("font_row_v32", int'(d_frow), 0);
                repeat (7) @(negedge clk);
                chk("char_addr_x47", int'(d_addr), 165);
                @(negedge clk);
                chk("char_addr_x48", int'(d_addr), 166);
            end
            // -------- small-timing instance: cursor behaviour across frames --------
            begin
                wait_pulse();
                ctl = 8'hF1;
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f1_block_pixels", c, 128);
                chk("f1_first_x", fx, 40);
                chk("f1_first_y", fy, 32);
                chk("f1_colour", colr, 15);
                chk("f1_frame_period", len, 4320);
                chk("f1_lines", hsf, 54);
                chk("f1_vsync_low", vsl, 160);
                ctl = 8'hF5;
                crx = 8'd80;
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f2_underline_pixels", c, 16);
                chk("f2_underline_y", fy, 46);
                crx = 8'd5;
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f3_crx80_pixels", c, 0);
                fork
                    measure(c, fx, fy, hsf, vsl, len, colr);
                    begin
                        repeat (1000) @(negedge clk);
                        crx = 8'd3;
                    end
                join
                chk("f4_midframe_pixels", c, 128);
                chk("f4_midframe_x", fx, 40);
                ctl = 8'hF7;
                crx = 8'd5;
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f5_moved_x", fx, 24);
                chk("f5_moved_pixels", c, 128);
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f6_blink_off", c, 0);
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f7_blink_off", c, 0);
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f8_blink_on", c, 128);
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f9_blink_on", c, 128);
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("f10_blink_off", c, 0);
                // Mid-frame reset while the blink phase is off
                repeat (1000) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                t = 0;
                while (s_hs !== 1'b0 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("rst_small_hsync_fall", t, 70);
                wait_pulse();
                measure(c, fx, fy, hsf, vsl, len, colr);
                chk("post_rst_blink_on", c, 128);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_text_scanout.md
# vga_text_scanout

Display-side consumer of the cursor/control registers that the CPU programs through the VGA controller (CTL at 0xF00, CRX at 0xF02, CRY at 0xF04). Runs in the 25 MHz pixel domain to generate 640x480@60 VGA timing for an 80x30 text screen of 8x16 cells. It drives the character-RAM read address and font row, and produces a registered, blinkable cursor overlay. Register values are shadow-latched once per frame so cursor moves never tear.

## Interface
- H_VISIBLE, 640, active pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
- V_VISIBLE, 480, active lines; V_FP 10, V_SYNC 2, V_BP 33 (frame total 525)
- COLS, 80, text columns; ROWS, 30, text rows
- BLINK_FRAMES, 16, frames per cursor blink half-period
- Clock  in  1  pixel clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Octl  in  8  control: [7:4] cursor colour, [3] reserved, [2] block(1)/underline(0), [1] blink enable, [0] cursor enable
- Ocrx  in  8  cursor column
- Ocry  in  8  cursor row
- CharAddr  out  12  character RAM address, row*80+col
- FontRow  out  4  scanline within the cell (VCount[3:0])
- PixelCol  out  3  pixel within the cell, aligned with RAM data
- HSync_L, VSync_L  out  1  active-low syncs
- VGABLANKING_L  out  1  low outside the visible area
- CursorOn  out  1  cursor overlay for the current pixel
- CursorColour  out  4  shadow Octl[7:4]
- FrameStart  out  1  one-cycle pulse when shadow registers load

## Operation
- HCount 0..799 increments every cycle and wraps to 0. VCount 0..524 increments on the HCount wrap and wraps to 0.
- Visible region: HCount<640 and VCount<480. In this region col=HCount[9:3] and row=VCount[8:4]. CharAddr=(row<<6)+(row<<4)+col. Outside the visible region CharAddr=0.
- HSync_L is low for HCount 656..751. VSync_L is low for VCount 490..491.
- Shadow load occurs in the cycle HCount==0 and VCount==480. In that cycle ShCtl/ShCrx/ShCry take Octl/Ocrx/Ocry and FrameStart pulses. Input changes at any other time are ignored until the next load.
- Blink: frame counter 0..BLINK_FRAMES-1 advances on each load. When it wraps, BlinkPhase toggles.
- CursorOn=1 iff all of the following hold:
  - visible region
  - ShCtl[0]=1
  - ShCrx<80 and ShCry<30
  - col==ShCrx and row==ShCry
  - ShCtl[2]=1, or FontRow is 14 or 15
  - ShCtl[1]=0, or BlinkPhase=1
- Out-of-range CRX/CRY values suppress the cursor entirely; they never wrap.
- Reset values:
  - counters 0, frame counter 0, BlinkPhase 1
  - shadow registers 0xF5/0x28/0x14
  - CharAddr 0, FontRow 0, PixelCol 0
  - HSync_L 1, VSync_L 1, VGABLANKING_L 0
  - CursorOn 0, CursorColour 0, FrameStart 0
- Reset mid-frame restarts the frame at HCount=VCount=0 on the next edge. The pipeline flushes to the reset values.

## Timing
- Stage 0: counters. Stage 1: CharAddr/FontRow registered, presented to a 1-cycle synchronous RAM. Stage 2: RAM data valid.
- PixelCol, HSync_L, VSync_L, VGABLANKING_L, CursorOn and CursorColour are registered at stage 2. They appear 2 cycles after the counter value they describe, aligned with the RAM data.
- FrameStart also has 2-cycle latency. Shadow registers update 1 cycle after the load cycle.
- Line period is 800 cycles; frame period is 420000 cycles. No stalls and no backpressure.

## Structure
- Shared package vga_pkg holds the timing constants, the init values (CTL 0xF5, CRX 0x28, CRY 0x14) and the Octl bit-field positions.
- One natural sub-module: vga_timing_gen (counters, sync/visible decode, frame-start strobe). vga_text_scanout adds the shadow registers, blink logic, address math and alignment pipeline.

## Test plan
- Reset 5 cycles, then release. Check:
  - all outputs hold reset values before the first edge after release
  - the first HSync_L falling edge appears 658 cycles after release
  - VGABLANKING_L rises 2 cycles after release.
- Run one frame. Check:
  - HSync_L low for exactly 96 cycles per line, 525 lines per frame
  - VSync_L low for 1600 cycles
  - FrameStart period 420000 cycles.
- At VCount=32, HCount=40 (row 2, col 5), check CharAddr=165 and FontRow=0.
- Octl=0xF5, Ocrx=5, Ocry=2 loaded at FrameStart. In the next frame, check CursorOn=1 for x 40..47, y 32..47 (exactly 128 pixels) and CursorColour=0xF.
- Variants on the cursor test:
  - Octl=0xF1 (underline): only y 46..47 set CursorOn.
  - Ocrx=80: CursorOn never asserts.
  - Ocrx changes mid-frame: cursor does not move until the following frame.
- Octl=0xF7 (blink): CursorOn is present for 16 frames, absent for 16, present again. Reset mid-frame restores BlinkPhase=1 and HCount=VCount=0.
